sample_feeder: RTL and testbench
================================

# sample_feeder

Input-side stage placed directly upstream of the adaptive notch filter wrapper. It buffers incoming signed samples in a small FIFO and presents one word at a time on the filter's data input. It issues a one-cycle sample trigger and then waits for the filter's `filter_done` handshake before releasing the next word. A watchdog and sticky status flags catch a stalled filter or lost input samples.

## Interface
- `DATA_SIZE`, 25: width parameter shared with the filter; sample words are `DATA_SIZE-1` bits, two's complement.
- `FIFO_DEPTH`, 8: FIFO depth in words; must be a power of 2, ≥2.
- `TIMEOUT`, 4096: watchdog limit, counted in clock cycles.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in `DATA_SIZE-1`: sample from the source.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: FIFO can accept a word; combinational, equal to `fill != FIFO_DEPTH`.
- `data_out` out `DATA_SIZE-1`: registered word driven to the filter's `data_in`.
- `sample` out 1: one-cycle trigger to the filter's `sample_trig`.
- `filter_done` in 1: completion indication from the filter; may be a level or a pulse.
- `fill` out `clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `overflow` out 1: sticky; set when `in_valid` is high while `in_ready` is low.
- `timeout` out 1: sticky watchdog flag.
- `clr_flags` in 1: synchronous clear of `overflow` and `timeout`.

## Operation
FIFO:
- Registered storage with wrap-around read and write pointers.
- Write occurs when `in_valid && in_ready`.
- Pop occurs only on the IDLE→ARM transition.
- No fall-through: a word written at edge k is first visible as non-empty after edge k.
- At full, the input is refused and `overflow` is set; the incoming word is discarded.
- A simultaneous write and pop leaves `fill` unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

FSM states:
- IDLE: if `fill != 0`, at the next edge load `data_out` with the FIFO head, pop it, assert `sample`, and go to ARM.
- ARM: lasts 1 cycle with `sample` = 1. Clear the watchdog counter and go to WAIT_LO.
- WAIT_LO: wait for `filter_done` = 0, so a stale high level from the previous sample is ignored. When it is 0, go to WAIT_HI.
- WAIT_HI: wait for `filter_done` = 1, then go to IDLE.
- Watchdog: in WAIT_LO and WAIT_HI the counter increments each cycle. On reaching `TIMEOUT`, set `timeout` and go to IDLE. The word is not retried.

Other rules:
- `data_out` holds its value from the ARM edge until the next ARM.
- `clr_flags` has priority over the setting conditions only for `timeout`. If `overflow` is being set in the same cycle as `clr_flags`, `overflow` is set (the set wins).
- No arithmetic is performed on the data; words pass through bit-exact.

## Timing
- Reset values: `data_out` = 0, `sample` = 0, `fill` = 0, `in_ready` = 1, `busy` = 0, `overflow` = 0, `timeout` = 0, FSM in IDLE, pointers and watchdog = 0.
- Latency: a word accepted at edge 0 into an empty FIFO with the FSM idle appears on `data_out`, with `sample` high, after edge 1 (for one cycle).
- The earliest return to IDLE is 3 edges after ARM (ARM→WAIT_LO→WAIT_HI→IDLE) when `filter_done` toggles low then high.
- With back-to-back FIFO data, the next `sample` follows 1 cycle after re-entering IDLE. The minimum sample spacing is therefore 4 cycles.
- Reset asserted mid-operation: all outputs go to their reset values immediately and asynchronously. `sample` drops even within its pulse cycle, and FIFO contents are discarded.
- `fill` and `busy` are registered; `in_ready` follows `fill` combinationally.

## Test plan
- Reset, then hold `filter_done` = 0 and push 0x000001 → `sample` high for exactly 1 cycle after edge 1, `data_out` = 0x000001. `busy` stays 1 until `filter_done` pulses high, then returns to 0.
- Push 8 words 0x100..0x107 with `filter_done` stuck at 0 → `fill` peaks at 7 (one word is already popped), and `in_ready` stays high.
- Push 10 words while the filter never completes → `fill` = 8, `in_ready` = 0, `overflow` = 1, and exactly 1 word is lost.
- Hold `filter_done` = 1 continuously before and after `sample` → the FSM stays in WAIT_LO. After 4096 cycles `timeout` = 1, and the next word issues. `clr_flags` then clears `timeout` to 0.
- Simultaneous push and pop at `fill` = 3 → `fill` stays 3, and output order is preserved across a pointer wrap (16 words 0x200..0x20F emerge in order).
- Assert `reset` during the cycle in which `sample` is high → `sample` = 0 in the same cycle, `fill` = 0, and `in_ready` = 1.

Source files
------------

// File: rtl/sample_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_feeder
// Purpose  : Input stage ahead of the adaptive notch filter wrapper. Buffers
//            signed samples in a small FIFO and hands one word at a time to
//            the filter. It pulses `sample`, then waits for the filter's
//            `filter_done` handshake before it releases the next word. A
//            watchdog and sticky flags report a stalled filter or input
//            words that were dropped.
//
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous, active-high reset
//            in_data      - incoming sample word (DATA_SIZE-1 bits, signed)
//            in_valid     - in_data valid this cycle
//            in_ready     - FIFO not full (combinational from fill)
//            data_out     - registered word to the filter data input
//            sample       - one-cycle trigger to the filter
//            filter_done  - filter completion (level or pulse)
//            fill         - FIFO occupancy
//            busy         - FSM not idle
//            overflow     - sticky, a word was offered while the FIFO was full
//            timeout      - sticky, the watchdog expired
//            clr_flags    - synchronous clear of overflow/timeout
//
// Revision : 1.0 - initial release
// ============================================================================
module sample_feeder #(
    parameter int DATA_SIZE  = 25,
    parameter int FIFO_DEPTH = 8,     // power of 2, >= 2
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_SIZE-2:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_SIZE-2:0]          data_out,
    output logic                          sample,
    input  logic                          filter_done,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          busy,
    output logic                          overflow,
    output logic                          timeout,
    input  logic                          clr_flags
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_FILL_W = c_AW + 1;
    localparam int c_WD_W   = $clog2(TIMEOUT + 1);
    localparam int c_WORD_W = DATA_SIZE - 1;

    localparam logic [c_FILL_W-1:0] c_FULL    = c_FILL_W'(FIFO_DEPTH);
    localparam logic [c_WD_W-1:0]   c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_WORD_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_FILL_W-1:0]  r_fill;
    logic [c_WD_W-1:0]    r_wdog;
    logic [c_WORD_W-1:0]  r_data_out;
    logic                 r_sample;
    logic                 r_busy;
    logic                 r_overflow;
    logic                 r_timeout;

    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wd_expire;

    assign w_in_ready = (r_fill != c_FULL);
    assign w_push     = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Next-state logic. The pop is tied to the IDLE->ARM transition, so
    // the FIFO head is consumed exactly when it is loaded into data_out.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_wd_expire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_fill != '0) begin
                    w_next_state = S_ARM;
                    w_pop        = 1'b1;
                end
            end
            S_ARM: begin
                w_next_state = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // A done level left over from the previous word must drop
                // first, otherwise it would be taken as this word's done.
                if (!filter_done) begin
                    w_next_state = S_WAIT_HI;
                end else if (r_wdog >= c_WD_LAST) begin
                    w_next_state = S_IDLE;
                    w_wd_expire  = 1'b1;
                end
            end
            S_WAIT_HI: begin
                // >= because the count may have reached TIMEOUT while the
                // FSM was moving out of WAIT_LO on the last cycle.
                if (filter_done) begin
                    w_next_state = S_IDLE;
                end else if (r_wdog >= c_WD_LAST) begin
                    w_next_state = S_IDLE;
                    w_wd_expire  = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, handshake outputs and watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
            r_wdog     <= '0;
            r_data_out <= '0;
        end else begin
            r_state  <= w_next_state;
            r_sample <= (w_next_state == S_ARM);
            r_busy   <= (w_next_state != S_IDLE);

            if (r_state == S_ARM) begin
                r_wdog <= '0;
            end else if ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI)) begin
                r_wdog <= r_wdog + c_WD_W'(1);
            end

            if (w_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the pointers and fill count
    // are cleared, which makes every stored word unreachable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags. A new overflow event beats clr_flags, while
    // clr_flags beats a new timeout event.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end

            if (clr_flags) begin
                r_timeout <= 1'b0;
            end else if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign data_out = r_data_out;
    assign sample   = r_sample;
    assign fill     = r_fill;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sample_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sample_feeder
// Purpose  : Directed self-checking bench for sample_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_feeder;

    localparam int DATA_SIZE  = 25;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 4096;

    logic                clk;
    logic                reset;
    logic [DATA_SIZE-2:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_SIZE-2:0] data_out;
    logic                sample;
    logic                filter_done;
    logic [3:0]          fill;
    logic                busy;
    logic                overflow;
    logic                timeout;
    logic                clr_flags;

    int n_cmp = 0;
    int n_err = 0;

    sample_feeder #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .sample      (sample),
        .filter_done (filter_done),
        .fill        (fill),
        .busy        (busy),
        .overflow    (overflow),
        .timeout     (timeout),
        .clr_flags   (clr_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge; return at the following falling edge where outputs
    // are sampled and new inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        filter_done = 1'b0;
        clr_flags   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Starts in WAIT_HI with filter_done low. Completes the current word,
    // optionally pushes one word on the same edge, checks the next issue,
    // and ends back in WAIT_HI.
    task automatic serve(input logic [23:0] exp, input bit push, input logic [23:0] pdata);
        filter_done = 1'b1;
        in_valid    = push;
        in_data     = pdata;
        step();
        in_valid    = 1'b0;
        filter_done = 1'b0;
        check("serve_idle_busy", busy, 0);
        step();
        check("serve_sample", sample, 1);
        check("serve_data", data_out, exp);
        step();
        check("serve_sample_width", sample, 0);
        step();
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        filter_done = 1'b0;
        clr_flags   = 1'b0;
        @(negedge clk);

        // ---------------- reset values ----------------
        check("rst_data_out", data_out, 0);
        check("rst_sample", sample, 0);
        check("rst_fill", fill, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        step();
        reset = 1'b0;

        // ---------------- single word latency ----------------
        in_valid = 1'b1;
        in_data  = 24'h000001;
        step();                                   // edge 0: write
        in_valid = 1'b0;
        check("t1_fill_after_write", fill, 1);
        check("t1_no_sample_yet", sample, 0);
        step();                                   // edge 1: ARM
        check("t1_sample", sample, 1);
        check("t1_data", data_out, 24'h000001);
        check("t1_busy", busy, 1);
        check("t1_fill_popped", fill, 0);
        step();
        check("t1_sample_one_cycle", sample, 0);
        step();
        step();
        check("t1_busy_waiting", busy, 1);
        check("t1_data_hold", data_out, 24'h000001);
        filter_done = 1'b1;
        step();
        filter_done = 1'b0;
        check("t1_busy_done", busy, 0);

        // ---------------- 8 words, filter stuck ----------------
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h000100 + 24'(i);
            step();
            check("t2_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        check("t2_fill_peak", fill, 7);
        check("t2_head_issued", data_out, 24'h000100);

        // ---------------- overflow, exactly one word lost ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_data   = 24'h000300 + 24'(i);
            clr_flags = (i == 9);                 // set must win over clear
            step();
        end
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        check("t3_fill_full", fill, 8);
        check("t3_in_ready_low", in_ready, 0);
        check("t3_overflow", overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            serve(24'h000300 + 24'(k), 1'b0, 24'h0);
        end
        filter_done = 1'b1;
        step();
        filter_done = 1'b0;
        check("t3_idle", busy, 0);
        step();
        check("t3_no_extra_sample", sample, 0);
        check("t3_drained", fill, 0);
        check("t3_overflow_sticky", overflow, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t3_overflow_cleared", overflow, 0);

        // ---------------- watchdog with stale filter_done ----------------
        do_reset();
        filter_done = 1'b1;
        in_valid    = 1'b1;
        in_data     = 24'h000400;
        step();                                   // edge 0
        in_data     = 24'h000401;
        step();                                   // edge 1: ARM + push
        in_valid    = 1'b0;
        check("t4_sample", sample, 1);
        check("t4_data", data_out, 24'h000400);
        check("t4_fill_push_pop", fill, 1);
        step();                                   // edge 2: WAIT_LO
        repeat (TIMEOUT - 1) step();
        check("t4_timeout_not_yet", timeout, 0);
        check("t4_still_busy", busy, 1);
        step();
        check("t4_timeout_set", timeout, 1);
        check("t4_idle_after_timeout", busy, 0);
        step();
        check("t4_next_sample", sample, 1);
        check("t4_next_data", data_out, 24'h000401);
        filter_done = 1'b0;
        step();
        step();
        filter_done = 1'b1;
        step();
        filter_done = 1'b0;
        check("t4_completed", busy, 0);
        check("t4_timeout_sticky", timeout, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("t4_timeout_cleared", timeout, 0);

        // ---------------- push+pop at fill 3, pointer wrap ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h000200 + 24'(i);
            step();
        end
        in_valid = 1'b0;
        check("t5_fill3", fill, 3);
        filter_done = 1'b1;
        step();
        filter_done = 1'b0;
        check("t5_idle_fill3", fill, 3);
        in_valid = 1'b1;
        in_data  = 24'h000204;
        step();                                   // push and pop together
        in_valid = 1'b0;
        check("t5_fill_unchanged", fill, 3);
        check("t5_sample", sample, 1);
        check("t5_data", data_out, 24'h000201);
        step();
        step();
        for (int k = 2; k <= 15; k++) begin
            serve(24'h000200 + 24'(k), (k <= 12), 24'h000203 + 24'(k));
            if (k <= 12) check("t5_fill_steady", fill, 3);
        end
        check("t5_fill_empty", fill, 0);

        // ---------------- reset inside the sample cycle ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 24'h000500;
        step();
        in_data  = 24'h000501;
        step();
        in_valid = 1'b0;
        check("t6_sample_before", sample, 1);
        check("t6_fill_before", fill, 1);
        reset = 1'b1;
        #1;
        check("t6_sample_async", sample, 0);
        check("t6_fill_async", fill, 0);
        check("t6_in_ready_async", in_ready, 1);
        check("t6_busy_async", busy, 0);
        check("t6_data_async", data_out, 0);
        step();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
